// File: rtl/stream_feeder_kernel_b_if.sv
// Valid/ready stream carrying memory words from the feeder to the kernel input.
// The master drives ovalid/data_s0; the slave (kernel) drives oready.
interface stream_feeder_kernel_b_if #(
  parameter int STREAMW = 32
) ();
  logic               ovalid;
  logic               oready;
  logic [STREAMW-1:0] data_s0;

  modport master (output ovalid, output data_s0, input  oready);
  modport slave  (input  ovalid, input  data_s0, output oready);
endinterface

// File: rtl/stream_feeder_kernel_b.sv
// Reads NELEMS words from a 1-cycle-latency memory and streams them out in
// address order through a 2-entry skid buffer, one word per cycle at full rate.
module stream_feeder_kernel_b #(
  parameter int STREAMW = 32,
  parameter int ADDRW   = 10,
  parameter int NELEMS  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_mem_rden,
  output logic [ADDRW-1:0]          o_mem_raddr,
  input  logic [STREAMW-1:0]        i_mem_rdata,
  stream_feeder_kernel_b_if.master  s_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDRW:0] LP_N    = (ADDRW+1)'(NELEMS);
  localparam logic [ADDRW:0] LP_LAST = LP_N - 1'b1;

  logic [1:0]         r_state;
  logic [ADDRW:0]     r_rd_cnt;
  logic [ADDRW:0]     r_tx_cnt;
  logic               r_inflight;
  logic [1:0]         r_count;
  logic [STREAMW-1:0] r_buf0;
  logic [STREAMW-1:0] r_buf1;

  logic               w_pop;
  logic               w_last;
  logic               w_rden;
  logic [2:0]         w_occ;

  // NOTE: combinational logic uses blocking '=', every always_ff uses '<=' so
  // all registers update from the same pre-edge values.
  always_comb begin
    w_pop  = (r_count != 2'd0) && s_out.oready;
    w_last = w_pop && (r_tx_cnt == LP_LAST);
    // A word popping this cycle frees its slot at the same edge the new read
    // lands, so counting it keeps 1 word/cycle without ever overflowing.
    w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_rden = (r_state == S_RUN) && (r_rd_cnt < LP_N) && (w_occ < 3'd2);
  end

  assign o_busy        = (r_state == S_RUN);
  assign o_done        = (r_state == S_DONE);
  assign o_mem_rden    = w_rden;
  assign o_mem_raddr   = r_rd_cnt[ADDRW-1:0];
  assign s_out.ovalid  = (r_count != 2'd0);
  assign s_out.data_s0 = r_buf0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) r_state <= S_RUN;
        S_RUN:   if (w_last)  r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rden;
      if (r_state == S_DONE) begin
        r_rd_cnt <= '0;
        r_tx_cnt <= '0;
      end else begin
        if (w_rden) r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_pop)  r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // Head always lives in r_buf0 so data_s0 is a plain register output.
  // NOTE: the two buffer words are reset (unlike a RAM) because data_s0 must
  // read zero out of reset; they are registers, not a memory macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_buf0  <= '0;
      r_buf1  <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_buf0 <= i_mem_rdata;
          else                 r_buf1 <= i_mem_rdata;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_buf0 <= i_mem_rdata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_feeder_kernel_b.sv
// Bench for stream_feeder_kernel_b: three instances (NELEMS 8, 1024, 1) with a
// 1-cycle memory model (mem[i] = i+100) and a scoreboard queue of expected words.
module tb_stream_feeder_kernel_b;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [NI-1:0] start  = '0;
  logic [NI-1:0] oready = '0;
  logic [NI-1:0] busy, done, rden, ovalid;
  logic [9:0]  raddr [NI];
  logic [31:0] data  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NE = (g == 0) ? 8 : (g == 1) ? 1024 : 1;
    logic [31:0] r_mem;
    logic        w_busy, w_done, w_rden;
    logic [9:0]  w_raddr;

    stream_feeder_kernel_b_if #(.STREAMW(32)) u_if ();
    assign u_if.oready = oready[g];

    stream_feeder_kernel_b #(.STREAMW(32), .ADDRW(10), .NELEMS(NE)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start[g]),
      .o_busy      (w_busy),
      .o_done      (w_done),
      .o_mem_rden  (w_rden),
      .o_mem_raddr (w_raddr),
      .i_mem_rdata (r_mem),
      .s_out       (u_if.master)
    );

    always @(posedge clk) if (w_rden) r_mem <= 32'(w_raddr) + 32'd100;

    assign busy[g]   = w_busy;
    assign done[g]   = w_done;
    assign rden[g]   = w_rden;
    assign raddr[g]  = w_raddr;
    assign ovalid[g] = u_if.ovalid;
    assign data[g]   = u_if.data_s0;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;
  bit mon_en  = 0;

  logic [31:0] exp_q [$];
  int cyc = 0;
  int nxt_rd, n_reads, max_addr, n_done, n_xfer;
  int last_xfer_cyc, done_cyc, busy_cyc, first_ov_cyc;
  logic        prev_ovalid, prev_ready, prev_busy;
  logic [31:0] prev_data;

  function automatic int ne(input int s);
    return (s == 0) ? 8 : (s == 1) ? 1024 : 1;
  endfunction

  task automatic mon_clear();
    exp_q.delete();
    nxt_rd = 0; n_reads = 0; max_addr = -1; n_done = 0; n_xfer = 0;
    last_xfer_cyc = -1; done_cyc = -1; busy_cyc = -1; first_ov_cyc = -1;
    prev_ovalid = 1'b0; prev_ready = 1'b0; prev_busy = 1'b0; prev_data = '0;
  endtask

  // Monitor: read order, hold-while-stalled and scoreboard data checks.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (rden[sel]) begin
        n_tests++;
        if (int'(raddr[sel]) !== nxt_rd) begin
          n_fail++;
          $display("FAIL rd_addr: got %0d expected %0d", raddr[sel], nxt_rd);
        end
        nxt_rd = (nxt_rd + 1) % ne(sel);
        n_reads++;
        if (int'(raddr[sel]) > max_addr) max_addr = int'(raddr[sel]);
      end
      if (prev_ovalid && !prev_ready) begin
        n_tests++;
        if (ovalid[sel] !== 1'b1 || data[sel] !== prev_data) begin
          n_fail++;
          $display("FAIL hold: ovalid=%b data=%0d expected ovalid=1 data=%0d",
                   ovalid[sel], data[sel], prev_data);
        end
      end
      if (ovalid[sel] && oready[sel]) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_word: got %0d expected no transfer", data[sel]);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (data[sel] !== e) begin
            n_fail++;
            $display("FAIL data: got %0d expected %0d", data[sel], e);
          end
        end
        n_xfer++;
        last_xfer_cyc = cyc;
      end
      if (busy[sel] && !prev_busy && busy_cyc < 0) busy_cyc = cyc;
      if (ovalid[sel] && !prev_ovalid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (done[sel]) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_ovalid = ovalid[sel];
      prev_ready  = oready[sel];
      prev_busy   = busy[sel];
      prev_data   = data[sel];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic launch();
    for (int i = 0; i < ne(sel); i++) exp_q.push_back(32'(i + 100));
    start[sel] = 1'b1;
    tick();
    start[sel] = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input bit rnd);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (rnd) oready[sel] = 1'($urandom_range(0, 1));
      tick();
      if (n_done >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_done: got %0d done pulses expected %0d", n_done, target);
    end
    oready[sel] = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_xfer(input int target);
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (n_xfer >= target) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_xfer: got %0d transfers expected %0d", n_xfer, target);
    end
  endtask

  task automatic end_checks(input int runs);
    expect_int("queue_empty", exp_q.size(), 0);
    expect_int("n_reads", n_reads, runs * ne(sel));
    expect_int("max_addr", max_addr, ne(sel) - 1);
    expect_int("n_done", n_done, runs);
    expect_int("done_after_last", done_cyc, last_xfer_cyc + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    for (int g = 0; g < NI; g++) begin
      expect_int("rst_busy",   int'(busy[g]),   0);
      expect_int("rst_done",   int'(done[g]),   0);
      expect_int("rst_rden",   int'(rden[g]),   0);
      expect_int("rst_ovalid", int'(ovalid[g]), 0);
      expect_int("rst_raddr",  int'(raddr[g]),  0);
      expect_int("rst_data",   int'(data[g]),   0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    sel = 0; mon_clear(); mon_en = 1;
    oready[0] = 1'b1;
    launch();
    wait_done(1, 40, 0);
    expect_int("first_ovalid", first_ov_cyc, busy_cyc + 2);
    expect_int("no_bubbles", last_xfer_cyc, first_ov_cyc + 7);
    end_checks(1);
    mon_en = 0;
  endtask

  task automatic test_backpressure();
    sel = 0; mon_clear(); mon_en = 1;
    oready[0] = 1'b1;
    launch();
    wait_xfer(4);
    oready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 1) expect_int("stall_rden", int'(rden[0]), 0);
    end
    expect_int("stall_reads", n_reads, 6);
    expect_int("stall_head", int'(data[0]), 104);
    oready[0] = 1'b1;
    wait_done(1, 40, 0);
    end_checks(1);
    mon_en = 0;
  endtask

  task automatic test_random();
    sel = 1; mon_clear(); mon_en = 1;
    oready[1] = 1'b1;
    launch();
    wait_done(1, 8000, 1);
    end_checks(1);
    mon_en = 0;
  endtask

  task automatic test_start_ignored();
    bit relaunched = 0;
    sel = 0; mon_clear(); mon_en = 1;
    oready[0] = 1'b1;
    launch();
    for (int k = 0; k < 40 && !relaunched; k++) begin
      if (done[0]) begin
        start[0] = 1'b1;
        tick();
        expect_int("idle_busy", int'(busy[0]), 0);
        expect_int("idle_done", int'(done[0]), 0);
        for (int i = 0; i < ne(0); i++) exp_q.push_back(32'(i + 100));
        tick();
        start[0] = 1'b0;
        expect_int("relaunch_busy", int'(busy[0]), 1);
        relaunched = 1;
      end else begin
        start[0] = (k == 2 || k == 4) ? 1'b1 : 1'b0;
        tick();
      end
    end
    start[0] = 1'b0;
    expect_int("relaunched", int'(relaunched), 1);
    wait_done(2, 40, 0);
    end_checks(2);
    mon_en = 0;
  endtask

  task automatic test_reset_mid();
    sel = 0; mon_clear(); mon_en = 1;
    oready[0] = 1'b1;
    launch();
    wait_xfer(5);
    oready[0] = 1'b0;
    repeat (2) tick();
    expect_int("pre_rst_reads", n_reads, 7);
    mon_en = 0;
    rst = 1'b1;
    tick();
    expect_int("mid_rst_ovalid", int'(ovalid[0]), 0);
    expect_int("mid_rst_busy",   int'(busy[0]),   0);
    expect_int("mid_rst_rden",   int'(rden[0]),   0);
    rst = 1'b0;
    oready[0] = 1'b1;
    tick();
    mon_clear(); mon_en = 1;
    launch();
    wait_done(1, 40, 0);
    end_checks(1);
    mon_en = 0;
  endtask

  task automatic test_single();
    sel = 2; mon_clear(); mon_en = 1;
    oready[2] = 1'b1;
    launch();
    wait_done(1, 20, 0);
    expect_int("single_xfer", n_xfer, 1);
    end_checks(1);
    mon_en = 0;
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_single();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
